// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin grant arbiter.
package arb_pkg;

  // Arbiter FSM: IDLE holds no grant, BUSY holds exactly one grant.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // Default maximum hold time when grant timeout is compiled in.
  localparam int DEFAULT_MAX_HOLD = 16;

  // Width of a binary requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/onehot2bin.sv
// One-hot to binary encoder. An all-zero input encodes to 0.
module onehot2bin #(
  parameter int N = 8,
  parameter int W = arb_pkg::idx_width(N)
) (
  input  logic [N-1:0] onehot,
  output logic [W-1:0] bin
);

  // OR together the indices of all set bits; exact for a one-hot input.
  always_comb begin
    bin = '0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) bin = bin | W'(i);
    end
  end

endmodule

// File: rtl/rr_pick.sv
// Masked priority picker: returns the first set bit of req at or above
// ptr, wrapping from N-1 back to 0. Purely combinational.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N = 8,
  parameter int W = idx_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] pick
);

  logic [N-1:0] mask;
  logic [N-1:0] masked;

  // Two-pass search: lowest bit of the requests at/above ptr, otherwise
  // the lowest bit of all requests (the wrapped-around pass).
  always_comb begin
    mask   = {N{1'b1}} << ptr;
    masked = req & mask;
    if (|masked) pick = masked & (~masked + N'(1));
    else         pick = req & (~req + N'(1));
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter with locked (held) grants.
// Optional macros:
//   ARB_TIMEOUT_EN - revoke a grant held for MAX_HOLD cycles and pulse preempt.
//   USE_POWER_PINS - adds vccd1/vssd1 supply pins.
// Handshake: a requester raises req[i] and keeps it high for as long as it
// needs the slot; it owns the slot while grant[i] is high and releases it
// by dropping req[i]. Other requests are ignored while a grant is held.
// state_dbg/ptr_dbg expose the FSM state and rotation pointer for checkers.
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 8,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
  parameter int W        = idx_width(N)
) (
`ifdef USE_POWER_PINS
  inout  wire          vccd1,
  inout  wire          vssd1,
`endif
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_valid,
  output logic         preempt,
  output arb_state_e   state_dbg,
  output logic [W-1:0] ptr_dbg
);

  arb_state_e   state;
  logic [W-1:0] ptr;
  logic [N-1:0] others;
  logic [N-1:0] pick_req;
  logic [W-1:0] pick_ptr;
  logic [N-1:0] pick;
  logic [W-1:0] ptr_next;
  logic         owner_req;
  logic         timeout;
  logic         release_now;

`ifdef ARB_TIMEOUT_EN
  logic [15:0]  hold_cnt;
  logic         preempt_q;
`endif

  // Binary index of the registered grant, so grant_idx is flop-derived.
  onehot2bin #(.N(N), .W(W)) u_enc (
    .onehot (grant),
    .bin    (grant_idx)
  );

  // Arbitration candidates: from IDLE search all requests from ptr; on a
  // release/revoke search everyone but the owner from the slot after it.
  always_comb begin
    others      = req & ~grant;
    owner_req   = |(req & grant);
    ptr_next    = grant_idx + W'(1);
`ifdef ARB_TIMEOUT_EN
    timeout     = owner_req && (hold_cnt == 16'(MAX_HOLD - 1));
`else
    timeout     = 1'b0;
`endif
    release_now = !owner_req || timeout;
    pick_req    = (state == IDLE) ? req : others;
    pick_ptr    = (state == IDLE) ? ptr : ptr_next;
  end

  rr_pick #(.N(N), .W(W)) u_pick (
    .req  (pick_req),
    .ptr  (pick_ptr),
    .pick (pick)
  );

  // FSM, registered grant, rotation pointer and (optionally) hold timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      ptr       <= '0;
`ifdef ARB_TIMEOUT_EN
      hold_cnt  <= '0;
      preempt_q <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      preempt_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= pick;
            state <= BUSY;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end
        end
        BUSY: begin
          if (release_now) begin
            ptr <= ptr_next;
            if (|others) begin
              grant <= pick;
            end else begin
              grant <= '0;
              state <= IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            hold_cnt  <= '0;
            preempt_q <= timeout;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= hold_cnt + 16'd1;
`endif
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  // Flop-derived outputs only; nothing here depends on req.
  always_comb begin
    grant_valid = |grant;
    state_dbg   = state;
    ptr_dbg     = ptr;
`ifdef ARB_TIMEOUT_EN
    preempt     = preempt_q;
`else
    preempt     = 1'b0;
`endif
  end

endmodule
